// File: rtl/ahbl_excl_monitor_if.sv
// AHB-Lite bus bundle with exclusive-access sideband (hexcl, hmaster, hexokay).
// The master modport drives the address phase; the slave modport drives the response.
interface ahbl_excl_monitor_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic              hready;
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
    logic [W_DATA-1:0] hwdata;
    logic              hexcl;
    logic [7:0]        hmaster;
    logic              hready_resp;
    logic              hresp;
    logic              hexokay;
    logic [W_DATA-1:0] hrdata;

    modport master (
        output hready, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
        output hexcl, hmaster,
        input  hready_resp, hresp, hrdata
    );

    modport slave (
        input  hready, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
        input  hexcl, hmaster,
        output hready_resp, hresp, hexokay, hrdata
    );
endinterface

// File: rtl/ahbl_excl_monitor.sv
// AHB-Lite exclusive-access monitor: per-master reservations, failing exclusive stores are
// suppressed and answered locally. Optional macro AHBL_EXCL_MONITOR_SNOOP_WRITE_EN makes plain writes clear reservations.
module ahbl_excl_monitor #(
    parameter int N_MASTERS = 2,
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32,
    parameter int GRAN_LOG2 = 2
) (
    input logic                  clk,
    input logic                  rst,
    ahbl_excl_monitor_if.slave   src,
    ahbl_excl_monitor_if.master  dst
);
    localparam int W_GRAN = W_ADDR - GRAN_LOG2;

    logic [N_MASTERS-1:0] res_valid_r;
    logic [W_GRAN-1:0]    res_addr_r [N_MASTERS];
    logic [N_MASTERS-1:0] res_valid_nxt_s;
    logic [W_GRAN-1:0]    res_addr_nxt_s [N_MASTERS];

    logic                 dph_active_r;
    logic                 dph_fail_r;
    logic                 dph_okay_r;
    logic [N_MASTERS-1:0] dph_own_r;

    logic                 accept_s;
    logic                 excl_rd_s;
    logic                 excl_wr_s;
    logic                 plain_wr_s;
    logic                 store_pass_s;
    logic                 store_fail_s;
    logic [W_GRAN-1:0]    addr_gran_s;
    logic [N_MASTERS-1:0] own_sel_s;
    logic [N_MASTERS-1:0] gran_hit_s;

    assign accept_s    = src.hready & src.htrans[1];
    assign excl_rd_s   = accept_s & src.hexcl & ~src.hwrite;
    assign excl_wr_s   = accept_s & src.hexcl & src.hwrite;
    assign plain_wr_s  = accept_s & ~src.hexcl & src.hwrite;
    assign addr_gran_s = src.haddr[W_ADDR-1:GRAN_LOG2];

    // Slot decode: own_sel is empty for out-of-range master IDs, so they never own a slot.
    always_comb begin
        own_sel_s  = '0;
        gran_hit_s = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            own_sel_s[m]  = (src.hmaster == 8'(m));
            gran_hit_s[m] = res_valid_r[m] & (res_addr_r[m] == addr_gran_s);
        end
    end

    assign store_pass_s = excl_wr_s & (|(own_sel_s & gran_hit_s));
    assign store_fail_s = excl_wr_s & ~store_pass_s;

    // Address-phase pass-through; a failing exclusive store is turned into IDLE.
    assign dst.hready    = src.hready;
    assign dst.haddr     = src.haddr;
    assign dst.hwrite    = src.hwrite;
    assign dst.htrans    = store_fail_s ? 2'b00 : src.htrans;
    assign dst.hsize     = src.hsize;
    assign dst.hburst    = src.hburst;
    assign dst.hprot     = src.hprot;
    assign dst.hmastlock = src.hmastlock;
    assign dst.hwdata    = src.hwdata;
    assign dst.hexcl     = src.hexcl;
    assign dst.hmaster   = src.hmaster;
    assign src.hrdata    = dst.hrdata;

    // Reservation next state: error clear first, address-phase update overrides it.
    always_comb begin
        res_valid_nxt_s = res_valid_r;
        res_addr_nxt_s  = res_addr_r;
        for (int m = 0; m < N_MASTERS; m++) begin
            if (dst.hresp && dph_own_r[m]) begin
                res_valid_nxt_s[m] = 1'b0;
            end else begin
                res_valid_nxt_s[m] = res_valid_r[m];
            end

            if (excl_rd_s && own_sel_s[m]) begin
                res_valid_nxt_s[m] = 1'b1;
                res_addr_nxt_s[m]  = addr_gran_s;
            end else if (store_pass_s && gran_hit_s[m]) begin
                res_valid_nxt_s[m] = 1'b0;
            end else if (store_fail_s && own_sel_s[m]) begin
                res_valid_nxt_s[m] = 1'b0;
`ifdef AHBL_EXCL_MONITOR_SNOOP_WRITE_EN
            end else if (plain_wr_s && gran_hit_s[m]) begin
                res_valid_nxt_s[m] = 1'b0;
`endif
            end else begin
                res_addr_nxt_s[m] = res_addr_nxt_s[m];
            end
        end
    end

`ifndef AHBL_EXCL_MONITOR_SNOOP_WRITE_EN
    logic unused_plain_wr_s;
    assign unused_plain_wr_s = plain_wr_s;
`endif

    // Reservation slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_r <= '0;
            for (int m = 0; m < N_MASTERS; m++) begin
                res_addr_r[m] <= '0;
            end
        end else begin
            res_valid_r <= res_valid_nxt_s;
            res_addr_r  <= res_addr_nxt_s;
        end
    end

    // Data-phase state, advanced whenever the bus moves on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dph_active_r <= 1'b0;
            dph_fail_r   <= 1'b0;
            dph_okay_r   <= 1'b0;
            dph_own_r    <= '0;
        end else if (src.hready) begin
            dph_active_r <= accept_s;
            dph_fail_r   <= store_fail_s;
            dph_okay_r   <= (excl_rd_s & (|own_sel_s)) | store_pass_s;
            dph_own_r    <= excl_rd_s ? own_sel_s : '0;
        end else begin
            dph_active_r <= dph_active_r;
            dph_fail_r   <= dph_fail_r;
            dph_okay_r   <= dph_okay_r;
            dph_own_r    <= dph_own_r;
        end
    end

    // Response mux: the suppressed store completes locally in one cycle.
    always_comb begin
        src.hready_resp = 1'b1;
        src.hresp       = 1'b0;
        src.hexokay     = 1'b0;
        if (rst) begin
            src.hready_resp = 1'b1;
            src.hresp       = 1'b0;
            src.hexokay     = 1'b0;
        end else if (dph_active_r && dph_fail_r) begin
            src.hready_resp = 1'b1;
            src.hresp       = 1'b0;
            src.hexokay     = 1'b0;
        end else begin
            src.hready_resp = dst.hready_resp;
            src.hresp       = dst.hresp;
            src.hexokay     = dph_active_r & dph_okay_r & dst.hready_resp & ~dst.hresp;
        end
    end
endmodule

// File: doc/ahbl_excl_monitor.md
AHBL_EXCL_MONITOR -- requirements
Module: ahbl_excl_monitor

Interface
REQ-001 Parameter N_MASTERS, default 2: number of reservation slots, indexed by hmaster.
REQ-002 Parameter W_ADDR, default 32: address width.
REQ-003 Parameter W_DATA, default 32: data width.
REQ-004 Parameter GRAN_LOG2, default 2: reservation granule is 2^GRAN_LOG2 bytes; haddr[W_ADDR-1:GRAN_LOG2] is compared.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst, src_hprot, src_hmastlock, src_hwdata  input  1/W_ADDR/1/2/3/3/4/1/W_DATA  AHBL slave port, fed by the arbiter's dst_* outputs.
REQ-008 src_hexcl  input  1  exclusive-access qualifier, address phase.
REQ-009 src_hmaster  input  8  master ID, address phase.
REQ-010 src_hready_resp, src_hresp, src_hexokay  output  1 each  data-phase response to the arbiter.
REQ-011 src_hrdata  output  W_DATA  read data, driven equal to dst_hrdata.
REQ-012 dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata  output  widths as REQ-007  AHBL master port to the slave.
REQ-013 dst_hready_resp, dst_hresp, dst_hrdata  input  1/1/W_DATA  slave response.

Function
REQ-014 An address phase is accepted when src_hready=1 and src_htrans[1]=1; the monitor adds no latency and no extra cycles.
REQ-015 All dst_* address-phase signals and dst_hready and dst_hwdata pass through combinationally, except dst_htrans, which is forced to 2'b00 for a failing exclusive store.
REQ-016 Each slot m holds res_valid[m] and res_addr[m] (W_ADDR-GRAN_LOG2 bits).
REQ-017 On an accepted exclusive read (hexcl=1, hwrite=0, hmaster<N_MASTERS), slot hmaster is set valid with the address granule, overwriting any prior entry; the data phase returns hexokay=1.
REQ-018 An exclusive store passes when res_valid[hmaster]=1 and res_addr[hmaster] matches; otherwise it fails.
REQ-019 A passing store is forwarded unchanged, clears every valid slot whose granule matches (including its own), and returns hexokay=1.
REQ-020 A failing store is suppressed (dst_htrans=IDLE), clears slot hmaster, and the monitor drives src_hready_resp=1, src_hresp=0, src_hexokay=0 for its data phase, independent of dst_hready_resp.
REQ-021 Exclusive access with hmaster>=N_MASTERS: read is forwarded with no slot update and hexokay=0; store fails per REQ-020.
REQ-022 A data-phase state register (dph_active, dph_fail, dph_okay) is loaded on every src_hready=1 cycle; it reads 0 when the accepted transfer is IDLE/BUSY.
REQ-023 Outside a failed-store data phase: src_hready_resp=dst_hready_resp, src_hresp=dst_hresp, src_hexokay=dph_okay & dst_hready_resp & ~dst_hresp.
REQ-024 Slave ERROR on an exclusive read clears that master's slot on the first error cycle.
REQ-025 Slot update priority in one cycle: error clear (REQ-024) first, then the address-phase update of the accepted transfer; for the same slot the address-phase update wins.
REQ-026 Non-exclusive reads and IDLE/BUSY transfers never modify slots.

Reset
REQ-027 rst=1 clears all res_valid and data-phase state; src_hready_resp=1, src_hresp=0, src_hexokay=0 while held.
REQ-028 Reset asserted mid-transfer discards reservations; the first exclusive store after reset fails.

Configuration
REQ-029 Macro AHBL_EXCL_MONITOR_SNOOP_WRITE_EN defined: any accepted non-exclusive write clears every slot whose granule matches.
REQ-030 Macro undefined: non-exclusive writes leave slots untouched; only exclusive stores clear.

Verification
REQ-031 Master 1 exclusive read 0x100 -> hexokay=1; exclusive store 0x100 -> forwarded, hexokay=1; slot 1 invalid.
REQ-032 Master 0 exclusive store 0x200, no reservation -> dst_htrans=0, hready_resp=1 same data cycle, hexokay=0, slave sees no write.
REQ-033 M0 and M1 reserve 0x300; M1 store 0x302 (same granule) passes -> M0 store 0x300 fails.
REQ-034 M0 reserves 0x400; M1 plain write 0x400 -> with SNOOP_WRITE_EN M0 store fails, without it passes.
REQ-035 Slave inserts 3 wait states on a passing store -> hexokay=0 during waits, 1 only on the completing cycle.
REQ-036 M0 reserves 0x500, rst pulsed one cycle -> M0 store 0x500 fails; hmaster=9 exclusive store -> fails.
